cla_divider: RTL and testbench
==============================

Name: cla_divider

Overview:
- Sequential unsigned restoring divider; the inverse-direction companion to the 4-bit carry look-ahead adder in the user area.
- Each iteration performs a trial subtraction with a WIDTH+1-bit borrow look-ahead subtractor: remainder + ~divisor + 1, using a generate/propagate look-ahead carry chain, with borrow = ~carry_out.
- Produces one quotient bit per cycle.
- Valid/ready handshakes on both input and output sides, for use behind the same logic analyzer / GPIO harness as the adder.

Parameters:
WIDTH, 4, operand width of dividend, divisor, quotient and remainder (min 2, max 16)

Ports:
- vccd1  inout  1  1.8V supply, present only under USE_POWER_PINS
- vssd1  inout  1  digital ground, present only under USE_POWER_PINS
- wb_clk_i  input  1  single clock; all state updates on rising edge
- wb_rstn_i  input  1  reset, synchronous, active-low
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  divider can accept operands
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result is from a zero divisor

Behaviour:
- Reset: wb_rstn_i sampled low at a rising edge sets state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- Reset mid-CALC or mid-DONE aborts the operation and discards the result; no out_valid follows.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands into Q=dividend, D=divisor, R=0 (WIDTH+1 bits), count=0. Go to CALC if divisor!=0, else DONE with zero-divisor result.
  - CALC: in_ready=0. Each cycle:
    - {R,Q} shifted left 1; T = R_shifted - {1'b0,D} via the look-ahead subtractor.
    - No borrow: R=T, Q[0]=1. Borrow: R=R_shifted, Q[0]=0.
    - count increments; after the WIDTH-th iteration go to DONE.
  - DONE: out_valid=1, quotient=Q, remainder=R[WIDTH-1:0]. All outputs held stable while out_ready=0. On out_valid&&out_ready, go to IDLE and drop out_valid the next cycle.
- Latency:
  - Operands accepted at edge k; out_valid high after edge k+WIDTH.
  - Zero divisor: out_valid high after edge k+1.
- Throughput: one division per WIDTH+2 cycles minimum. in_ready is low in CALC and DONE, so acceptance never overlaps output handshake.
- Zero divisor: quotient = all ones, remainder = dividend, div_by_zero=1. div_by_zero is 0 for every other result.
- quotient, remainder and div_by_zero keep their last values in IDLE. They are meaningful only while out_valid=1.
- in_valid during CALC/DONE is ignored; operands are not sampled.
- Operand inputs may change freely after the accepting edge.
- out_ready high in a cycle where out_valid=0 has no effect.
- No arithmetic overflow is possible: quotient <= dividend and remainder < divisor always hold for divisor!=0.

Optional Feature:
CLA_DIV_OPCOUNT_EN
- Defined: adds output op_count [7:0].
  - Increments by 1 on every completed output handshake (out_valid&&out_ready), zero-divisor results included.
  - Wraps 255 -> 0; reset to 0 by wb_rstn_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WIDTH=4; 13/3 accepted at edge k, out_ready=1 -> out_valid after edge k+4; quotient=4, remainder=1, div_by_zero=0; out_valid low and in_ready high the following cycle.
- 15/1 then 2/7 back-to-back -> quotient=15 rem=0, then quotient=0 rem=2. in_ready low throughout each CALC/DONE; exactly two results.
- 5/0 -> out_valid after 1 cycle; quotient=15, remainder=5, div_by_zero=1. Next op 9/4 -> quotient=2, rem=1, div_by_zero=0.
- 14/5 with out_ready held 0 for 3 cycles after out_valid -> quotient=2, rem=4 stable all 3 cycles; in_ready=0; extra in_valid pulses ignored; handshake on 4th cycle.
- Start 11/2, assert wb_rstn_i=0 for one edge during 2nd CALC cycle -> all outputs at reset values, no out_valid. Then 11/2 -> quotient=5, rem=1.
- Exhaustive sweep of all 256 dividend/divisor pairs (WIDTH=4) against a reference model. With CLA_DIV_OPCOUNT_EN: op_count=0 after 256 handshakes (wrap).

Source files
------------

// File: rtl/cla_divider_if.sv
// Operand/result handshake bundle for cla_divider.
// op_count is present only when CLA_DIV_OPCOUNT_EN is defined.
interface cla_divider_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef CLA_DIV_OPCOUNT_EN
    logic [7:0]       op_count;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, op_count
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, op_count
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/cla_divider.sv
// Sequential restoring divider, one quotient bit per cycle, trial subtraction by a look-ahead adder.
// Optional CLA_DIV_OPCOUNT_EN adds an 8-bit handshake counter; USE_POWER_PINS adds vccd1/vssd1.
module cla_divider #(
    parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
    inout wire           vccd1,
    inout wire           vssd1,
`endif
    input  logic         wb_clk_i,
    input  logic         wb_rstn_i,
    cla_divider_if.slave bus
);
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             zero_reg, zero_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;
    logic             in_ready_c, out_valid_c;

    // Flat look-ahead carry into bit idx+1 with carry-in fixed at 1 (two's-complement subtract).
    function automatic logic lookahead(input logic [N-1:0] g, input logic [N-1:0] p, input int idx);
        logic c;
        logic term;
        c = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (j <= idx) c = c & p[j];
        end
        for (int j = 0; j < N; j++) begin
            if (j <= idx) begin
                term = g[j];
                for (int k = 0; k < N; k++) begin
                    if (k > j && k <= idx) term = term & p[k];
                end
                c = c | term;
            end
        end
        return c;
    endfunction

    logic [N-1:0] sub_a, sub_b, gen, prop, diff;
    logic [N:0]   carry;
    logic         borrow;
    logic [WIDTH-1:0] q_iter;
    logic [WIDTH:0]   r_iter;

    // Shifted partial remainder; R < D keeps r_reg[WIDTH] zero, so it falls off the top.
    assign sub_a    = N'({r_reg, q_reg[WIDTH-1]});
    assign sub_b    = ~{1'b0, d_reg};
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cla
            assign gen[gi]     = sub_a[gi] & sub_b[gi];
            assign prop[gi]    = sub_a[gi] ^ sub_b[gi];
            assign carry[gi+1] = lookahead(gen, prop, gi);
            assign diff[gi]    = prop[gi] ^ carry[gi];
        end
    endgenerate

    assign borrow = ~carry[N];
    assign q_iter = {q_reg[WIDTH-2:0], ~borrow};
    assign r_iter = borrow ? sub_a : diff;

    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        r_next         = r_reg;
        count_next     = count_reg;
        zero_next      = zero_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        in_ready_c     = 1'b0;
        out_valid_c    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    q_next     = bus.dividend;
                    d_next     = bus.divisor;
                    r_next     = '0;
                    count_next = '0;
                    zero_next  = (bus.divisor == '0);
                    state_next = CALC;
                end
            end
            CALC: begin
                if (zero_reg) begin
                    // Zero divisor spends a single cycle here so its result lands one edge after acceptance.
                    quotient_next  = '1;
                    remainder_next = q_reg;
                    dbz_next       = 1'b1;
                    state_next     = DONE;
                end else begin
                    q_next     = q_iter;
                    r_next     = r_iter;
                    count_next = count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1)) begin
                        quotient_next  = q_iter;
                        remainder_next = r_iter[WIDTH-1:0];
                        dbz_next       = 1'b0;
                        state_next     = DONE;
                    end
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_reg     <= IDLE;
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            count_reg     <= '0;
            zero_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            r_reg         <= r_next;
            count_reg     <= count_next;
            zero_reg      <= zero_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;

`ifdef CLA_DIV_OPCOUNT_EN
    logic [7:0] op_count_reg;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            op_count_reg <= '0;
        end else if (out_valid_c && bus.out_ready) begin
            op_count_reg <= op_count_reg + 8'd1;
        end
    end

    assign bus.op_count = op_count_reg;
`endif
endmodule

// File: tb/tb_cla_divider.sv
// Self-checking bench for cla_divider (WIDTH=4): directed scenarios, randomized noise and a full operand sweep.
module tb_cla_divider;
    localparam int WIDTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cla_divider_if #(.WIDTH(WIDTH)) bus ();

`ifdef USE_POWER_PINS
    wire vccd1 = 1'b1;
    wire vssd1 = 1'b0;
`endif

    cla_divider #(.WIDTH(WIDTH)) dut (
`ifdef USE_POWER_PINS
        .vccd1     (vccd1),
        .vssd1     (vssd1),
`endif
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hs_count  = 0;

    always @(posedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) hs_count <= hs_count + 1;
    end

    // Reference: plain integer division, with the all-ones / dividend convention for divisor 0.
    function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r, output logic z);
        if (b == 4'd0) begin
            q = 4'hF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Runs one division starting at a negedge; returns at the negedge after the output handshake.
    // bad flags: busy while in_ready high, unstable held outputs, or no result within the bound.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int stall,
                          output logic [3:0] q, output logic [3:0] r, output logic z,
                          output int lat, output bit bad);
        logic [3:0] q0, r0;
        logic       z0;
        bad = 1'b0;
        if (bus.in_ready !== 1'b1) bad = 1'b1;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            if (bus.in_ready !== 1'b0) bad = 1'b1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dividend = 4'($urandom);
            bus.divisor  = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        if (lat >= 64) bad = 1'b1;
        q0 = bus.quotient; r0 = bus.remainder; z0 = bus.div_by_zero;
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dividend = 4'($urandom);
            bus.divisor  = 4'($urandom);
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.quotient !== q0 ||
                bus.remainder !== r0 || bus.div_by_zero !== z0) bad = 1'b1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("op %0d/%0d stall=%0d -> q=%0d r=%0d dbz=%0d lat=%0d bad=%0d", a, b, stall, q, r, z, lat, bad);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.quotient !== 4'd0) $display("FAIL reset_quotient got=%0d want=0", bus.quotient); else pass_cnt++;
        total_cnt++; if (bus.remainder !== 4'd0) $display("FAIL reset_remainder got=%0d want=0", bus.remainder); else pass_cnt++;
        total_cnt++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); else pass_cnt++;
`ifdef CLA_DIV_OPCOUNT_EN
        total_cnt++; if (bus.op_count !== 8'd0) $display("FAIL reset_op_count got=%0d want=0", bus.op_count); else pass_cnt++;
`endif
    endtask

    task automatic test_basic();
        logic [3:0] q, r; logic z; int lat; bit bad;
        run_op(4'd13, 4'd3, 0, q, r, z, lat, bad);
        total_cnt++; if (lat !== WIDTH) $display("FAIL basic_latency got=%0d want=%0d", lat, WIDTH); else pass_cnt++;
        total_cnt++; if ({q, r, z} !== {4'd4, 4'd1, 1'b0}) $display("FAIL basic_result got q=%0d r=%0d z=%b want q=4 r=1 z=0", q, r, z); else pass_cnt++;
        total_cnt++; if (bad) $display("FAIL basic_protocol got bad=1 want bad=0"); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL basic_after got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] q, r; logic z; int lat; bit bad1, bad2; int hs0;
        hs0 = hs_count;
        run_op(4'd15, 4'd1, 0, q, r, z, lat, bad1);
        total_cnt++; if ({q, r, z} !== {4'd15, 4'd0, 1'b0}) $display("FAIL b2b_first got q=%0d r=%0d z=%b want q=15 r=0 z=0", q, r, z); else pass_cnt++;
        run_op(4'd2, 4'd7, 0, q, r, z, lat, bad2);
        total_cnt++; if ({q, r, z} !== {4'd0, 4'd2, 1'b0}) $display("FAIL b2b_second got q=%0d r=%0d z=%b want q=0 r=2 z=0", q, r, z); else pass_cnt++;
        total_cnt++; if (bad1 || bad2) $display("FAIL b2b_protocol got bad=%0d/%0d want 0/0", bad1, bad2); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (hs_count - hs0 !== 2) $display("FAIL b2b_count got=%0d want=2", hs_count - hs0); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        logic [3:0] q, r; logic z; int lat; bit bad;
        run_op(4'd5, 4'd0, 0, q, r, z, lat, bad);
        total_cnt++; if (lat !== 1) $display("FAIL dz_latency got=%0d want=1", lat); else pass_cnt++;
        total_cnt++; if ({q, r, z} !== {4'd15, 4'd5, 1'b1}) $display("FAIL dz_result got q=%0d r=%0d z=%b want q=15 r=5 z=1", q, r, z); else pass_cnt++;
        run_op(4'd9, 4'd4, 0, q, r, z, lat, bad);
        total_cnt++; if ({q, r, z} !== {4'd2, 4'd1, 1'b0}) $display("FAIL dz_next got q=%0d r=%0d z=%b want q=2 r=1 z=0", q, r, z); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [3:0] q, r; logic z; int lat; bit bad; int hs0;
        hs0 = hs_count;
        run_op(4'd14, 4'd5, 3, q, r, z, lat, bad);
        total_cnt++; if ({q, r, z} !== {4'd2, 4'd4, 1'b0}) $display("FAIL stall_result got q=%0d r=%0d z=%b want q=2 r=4 z=0", q, r, z); else pass_cnt++;
        total_cnt++; if (bad) $display("FAIL stall_hold got bad=1 want bad=0"); else pass_cnt++;
        total_cnt++; if (hs_count - hs0 !== 1) $display("FAIL stall_count got=%0d want=1", hs_count - hs0); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic [3:0] q, r; logic z; int lat; bit bad, seen;
        bus.in_valid = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        total_cnt++; if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0})
            $display("FAIL abort_reset got rdy=%b ov=%b q=%0d r=%0d z=%b want 1/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL abort_no_result got out_valid=1 want 0"); else pass_cnt++;
        run_op(4'd11, 4'd2, 0, q, r, z, lat, bad);
        total_cnt++; if ({q, r, z} !== {4'd5, 4'd1, 1'b0}) $display("FAIL abort_retry got q=%0d r=%0d z=%b want q=5 r=1 z=0", q, r, z); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0] a, b, q, r, eq, er; logic z, ez; int lat; bit bad;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            if (i % 6 == 0) b = 4'd0;
            run_op(a, b, $urandom_range(0, 3), q, r, z, lat, bad);
            model(a, b, eq, er, ez);
            total_cnt++; if ({q, r, z} !== {eq, er, ez} || bad)
                $display("FAIL random %0d/%0d got q=%0d r=%0d z=%b bad=%0d want q=%0d r=%0d z=%b bad=0", a, b, q, r, z, bad, eq, er, ez); else pass_cnt++;
        end
    endtask

    task automatic test_sweep();
        logic [3:0] a, b, q, r, eq, er; logic z, ez; int lat, elat; bit bad;
        apply_reset();
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a = 4'(ai); b = 4'(bi);
                run_op(a, b, $urandom_range(0, 2), q, r, z, lat, bad);
                model(a, b, eq, er, ez);
                elat = (b == 4'd0) ? 1 : WIDTH;
                total_cnt++; if ({q, r, z} !== {eq, er, ez})
                    $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", a, b, q, r, z, eq, er, ez); else pass_cnt++;
                total_cnt++; if (lat !== elat || bad)
                    $display("FAIL sweep_timing %0d/%0d got lat=%0d bad=%0d want lat=%0d bad=0", a, b, lat, bad, elat); else pass_cnt++;
`ifdef CLA_DIV_OPCOUNT_EN
                if (ai == 0 && bi == 0) begin
                    total_cnt++; if (bus.op_count !== 8'd1) $display("FAIL sweep_op_count_first got=%0d want=1", bus.op_count); else pass_cnt++;
                end
`endif
            end
        end
`ifdef CLA_DIV_OPCOUNT_EN
        total_cnt++; if (bus.op_count !== 8'd0) $display("FAIL sweep_op_count_wrap got=%0d want=0", bus.op_count); else pass_cnt++;
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_stall();
        test_reset_abort();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
